axi_lite_regfile_slave: RTL

//   Parametrised AXI4-Lite slave register file, next generation of the project's AXI demo slave.

---
 rtl/axi_lite_regfile_slave.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_regfile_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_regfile_slave
// Purpose  : AXI4-Lite slave register file with independent AW/W acceptance,
//            per-byte write strobes, OKAY/SLVERR responses and a registered
//            mirror of one register for the display pins.
// Ports    : clk, rst (async, active high)
//            AW : awaddr_i, awvalid_i, awready_o
//            W  : wdata_i, wstrb_i, wvalid_i, wready_o
//            B  : bresp_o, bvalid_o, bready_i
//            AR : araddr_i, arvalid_i, arready_o
//            R  : rdata_o, rresp_o, rvalid_o, rready_i
//            disp_out_o : live copy of register DISP_REG
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_regfile_slave #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NREGS    = 16,
  parameter int unsigned DISP_REG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic                arvalid_i,
  output logic                arready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rvalid_o,
  input  logic                rready_i,
  output logic [DATA_W-1:0]   disp_out_o
);

  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_SERR = 2'b10;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_HAVE_AW = 2'd1,
    WR_HAVE_W  = 2'd2,
    WR_RESP    = 2'd3
  } wr_state_t;

  typedef enum logic [0:0] {
    RD_IDLE = 1'b0,
    RD_RESP = 1'b1
  } rd_state_t;

  // Register storage and channel state
  logic [DATA_W-1:0] regs_q [NREGS];
  wr_state_t         wr_state_q;
  rd_state_t         rd_state_q;
  logic              awready_q, wready_q, bvalid_q;
  logic [1:0]        bresp_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [STRB_W-1:0] strb_q;
  logic              arready_q, rvalid_q;
  logic [1:0]        rresp_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] disp_q;

  // Commit path (combinational view of the write that lands on this edge)
  logic              aw_hs, w_hs, ar_hs;
  logic              commit_en, commit_ok;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic [STRB_W-1:0] commit_strb;
  logic [DATA_W-1:0] rd_val;
  logic              rd_ok;
  logic [DATA_W-1:0] disp_d;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < NREGS;
  endfunction

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_v,
                                                   input logic [DATA_W-1:0] new_v,
                                                   input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] res;
    res = old_v;
    for (int b = 0; b < int'(STRB_W); b++) begin
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign aw_hs = awvalid_i & awready_q;
  assign w_hs  = wvalid_i  & wready_q;
  assign ar_hs = arvalid_i & arready_q;

  // The address/data pair that commits depends on which half arrived first:
  // the latched half comes from *_q, the half handshaking now from the bus.
  always_comb begin
    commit_en   = 1'b0;
    commit_addr = addr_q;
    commit_data = data_q;
    commit_strb = strb_q;
    case (wr_state_q)
      WR_IDLE: begin
        if (aw_hs && w_hs) begin
          commit_en   = 1'b1;
          commit_addr = awaddr_i;
          commit_data = wdata_i;
          commit_strb = wstrb_i;
        end
      end
      WR_HAVE_AW: begin
        if (w_hs) begin
          commit_en   = 1'b1;
          commit_data = wdata_i;
          commit_strb = wstrb_i;
        end
      end
      WR_HAVE_W: begin
        if (aw_hs) begin
          commit_en   = 1'b1;
          commit_addr = awaddr_i;
        end
      end
      default: commit_en = 1'b0;
    endcase
    commit_ok = in_range(commit_addr);
  end

  // Read mux; out-of-range addresses match no entry and return zero
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < int'(NREGS); i++) begin
      if (araddr_i == ADDR_W'(i)) rd_val = regs_q[i];
    end
    rd_ok = in_range(araddr_i);
  end

  // Display mirror tracks the register's next value so it changes on the
  // same edge as the register itself.
  always_comb begin
    disp_d = regs_q[DISP_REG];
    if (commit_en && commit_ok && (commit_addr == ADDR_W'(DISP_REG))) begin
      disp_d = merge_bytes(regs_q[DISP_REG], commit_data, commit_strb);
    end
  end

  // Register array and display mirror
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
      disp_q <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (commit_en && commit_ok && (commit_addr == ADDR_W'(i))) begin
          regs_q[i] <= merge_bytes(regs_q[i], commit_data, commit_strb);
        end
      end
      disp_q <= disp_d;
    end
  end

  // Write FSM. Ready flags are registered; IDLE re-arms them one cycle after
  // reset or after a B handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      addr_q     <= '0;
      data_q     <= '0;
      strb_q     <= '0;
    end else begin
      case (wr_state_q)
        WR_IDLE: begin
          if (aw_hs && w_hs) begin
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= commit_ok ? RESP_OKAY : RESP_SERR;
            wr_state_q <= WR_RESP;
          end else if (aw_hs) begin
            addr_q     <= awaddr_i;
            awready_q  <= 1'b0;
            wready_q   <= 1'b1;
            wr_state_q <= WR_HAVE_AW;
          end else if (w_hs) begin
            data_q     <= wdata_i;
            strb_q     <= wstrb_i;
            wready_q   <= 1'b0;
            awready_q  <= 1'b1;
            wr_state_q <= WR_HAVE_W;
          end else begin
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
          end
        end
        WR_HAVE_AW: begin
          if (w_hs) begin
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= commit_ok ? RESP_OKAY : RESP_SERR;
            wr_state_q <= WR_RESP;
          end
        end
        WR_HAVE_W: begin
          if (aw_hs) begin
            awready_q  <= 1'b0;
            bvalid_q   <= 1'b1;
            bresp_q    <= commit_ok ? RESP_OKAY : RESP_SERR;
            wr_state_q <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bready_i) begin
            bvalid_q   <= 1'b0;
            wr_state_q <= WR_IDLE;
          end
        end
        default: wr_state_q <= WR_IDLE;
      endcase
    end
  end

  // Read FSM. Data is sampled from regs_q before any same-edge commit, so a
  // colliding write is not visible to the read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state_q <= RD_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      case (rd_state_q)
        RD_IDLE: begin
          if (ar_hs) begin
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b1;
            rdata_q    <= rd_ok ? rd_val : '0;
            rresp_q    <= rd_ok ? RESP_OKAY : RESP_SERR;
            rd_state_q <= RD_RESP;
          end else begin
            arready_q  <= 1'b1;
          end
        end
        RD_RESP: begin
          if (rready_i) begin
            rvalid_q   <= 1'b0;
            rd_state_q <= RD_IDLE;
          end
        end
        default: rd_state_q <= RD_IDLE;
      endcase
    end
  end

  assign awready_o  = awready_q;
  assign wready_o   = wready_q;
  assign bvalid_o   = bvalid_q;
  assign bresp_o    = bresp_q;
  assign arready_o  = arready_q;
  assign rvalid_o   = rvalid_q;
  assign rresp_o    = rresp_q;
  assign rdata_o    = rdata_q;
  assign disp_out_o = disp_q;

endmodule
`default_nettype wire
